fir_filter: RTL and testbench



---
 rtl/fir_filter.sv | 78 +++++++
 tb/tb_fir_filter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fir_filter.sv
// Direct-form unsigned FIR filter with fixed coefficients and a saturating registered output.
// One sample in and one filtered sample out on every rising clock edge.
module fir_filter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TAPS   = 4,
    parameter int unsigned COEF_W = 8,
    parameter logic [TAPS*COEF_W-1:0] COEFFS = {8'd4, 8'd3, 8'd2, 8'd1}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y
);

    localparam int unsigned CLOG_TAPS = $clog2(TAPS);
    localparam int unsigned ACC_W     = DATA_W + COEF_W + CLOG_TAPS;
    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    // tap_c[0] is the live input, tap_c[k] is the sample taken k edges earlier
    logic [DATA_W-1:0] tap_c [TAPS];
    logic [ACC_W-1:0]  acc_c;
    logic [DATA_W-1:0] y_c;

    generate
        if (TAPS > 1) begin : g_dly
            logic [DATA_W-1:0] d [TAPS-1];

            // Delay line; cleared on reset so history reads as zeros after release
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int unsigned i = 0; i < TAPS-1; i++) begin
                        d[i] <= '0;
                    end
                end else begin
                    d[0] <= x;
                    for (int unsigned i = 1; i < TAPS-1; i++) begin
                        d[i] <= d[i-1];
                    end
                end
            end

            always_comb begin
                tap_c[0] = x;
                for (int unsigned k = 1; k < TAPS; k++) begin
                    tap_c[k] = d[k-1];
                end
            end
        end else begin : g_nodly
            always_comb begin
                tap_c[0] = x;
            end
        end
    endgenerate

    // Accumulator is wide enough that the sum of all products cannot overflow
    always_comb begin
        acc_c = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            acc_c = acc_c + ACC_W'(tap_c[k]) * ACC_W'(COEFFS[k*COEF_W +: COEF_W]);
        end
    end

    always_comb begin
        y_c = acc_c[DATA_W-1:0];
        if (acc_c > SAT_MAX) begin
            y_c = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            y <= '0;
        end else begin
            y <= y_c;
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: the driver pushes expected outputs, a monitor compares each edge.
module tb_fir_filter;

    logic       clk;
    logic       rst;
    logic [7:0] x;
    logic [7:0] y;

    typedef struct {
        string name;
        int    exp;
    } exp_t;

    exp_t sb_q [$];
    int   hist [$];
    int   coef [4] = '{1, 2, 3, 4};
    int   checks = 0;
    int   errors = 0;

    fir_filter dut (
        .clk(clk),
        .rst(rst),
        .x  (x),
        .y  (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: y = min(255, sum of c[k] * (input k samples ago)), with history zeroed by reset
    task automatic model(input bit r, input int v, output int res);
        int acc;
        if (!r) begin
            hist = '{0, 0, 0};
            res  = 0;
        end else begin
            acc = coef[0] * v;
            for (int k = 1; k < 4; k++) acc += coef[k] * hist[k-1];
            hist.push_front(v);
            void'(hist.pop_back());
            res = (acc > 255) ? 255 : acc;
        end
    endtask

    // Drive one edge; known >= 0 gives a hand-derived expected value, otherwise the model's
    task automatic step(input string name, input bit r, input int v, input int known);
        exp_t e;
        int   m;
        rst = r;
        x   = 8'(v);
        model(r, v, m);
        e.name = name;
        e.exp  = (known >= 0) ? known : m;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every rising edge produces one output, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (y !== 8'(e.exp)) begin
                    errors++;
                    $display("FAIL %s: y=%0d expected=%0d at %0t", e.name, y, e.exp, $time);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int imp [6] = '{1, 2, 3, 4, 0, 0};
        int stp [6] = '{1, 3, 6, 10, 10, 10};
        int sat_hi [5] = '{30, 90, 180, 255, 255};
        int sat_lo [4] = '{255, 210, 120, 0};

        rst = 1'b0;
        x   = 8'hFF;

        step("reset_hold", 1'b0, 255, 0);
        step("reset_hold", 1'b0, 255, 0);
        for (int i = 0; i < 3; i++) step("reset_release", 1'b1, 0, 0);

        for (int i = 0; i < 6; i++) step("impulse", 1'b1, (i == 0) ? 1 : 0, imp[i]);

        step("reset_pre_step", 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) step("step", 1'b1, 1, stp[i]);

        step("reset_pre_sat", 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) step("sat_rise", 1'b1, 30, sat_hi[i]);
        for (int i = 0; i < 4; i++) step("sat_fall", 1'b1, 0, sat_lo[i]);

        step("reset_pre_mid", 1'b0, 0, 0);
        step("mid_impulse", 1'b1, 1, 1);
        step("mid_impulse", 1'b1, 0, 2);
        step("mid_reset", 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) step("mid_after", 1'b1, 0, 0);

        // Random stream with occasional mid-stream resets
        for (int i = 0; i < 200; i++) begin
            bit r;
            r = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 3) == 0)
                step("random", r, int'($urandom_range(200, 255)), -1);
            else
                step("random", r, int'($urandom_range(0, 255)), -1);
        end

        rst = 1'b1;
        x   = 8'd0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
